// File: rtl/dec_scan_ctrl.sv
// dec_scan_ctrl: masked 3-to-8 decoder scan controller with programmable dwell and blanking gap
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   run   : 1 = scan, 0 = stop (next state IDLE)
//   div   : dwell length minus 1 (digit shows for div+1 cycles)
//   mask  : bit i set = select value i is visited
//   sel   : registered decoder select
//   en    : registered decoder enable
//   step  : one-cycle pulse when sel advances out of a blank gap
//   frame : one-cycle pulse when that advance wraps (new sel <= old sel)
module dec_scan_ctrl #(
   parameter int DIV_W     = 16,
   parameter int BLANK_CYC = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [DIV_W-1:0] div,
   input  logic [7:0]       mask,
   output logic [2:0]       sel,
   output logic             en,
   output logic             step,
   output logic             frame
);
   localparam int BW = BLANK_CYC > 1 ? $clog2(BLANK_CYC) : 1;
   typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
   state_t           state_q, state_d;
   logic [2:0]       sel_q, sel_d, nxt;
   logic             en_q, en_d, step_q, step_d, frame_q, frame_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [BW-1:0]    bcnt_q, bcnt_d;
   // First set bit of m searching s+1, s+2, ... cyclically, s itself last.
   // Iterating from the farthest offset down lets the nearest hit win.
   function automatic logic [2:0] next_sel(input logic [2:0] s, input logic [7:0] m);
      logic [2:0] r, idx;
      r = s;
      for (int k = 8; k >= 1; k--) begin
         idx = s + 3'(k);
         if (m[idx]) r = idx;
      end
      return r;
   endfunction
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      bcnt_d  = bcnt_q;
      step_d  = 1'b0;
      frame_d = 1'b0;
      nxt     = next_sel(sel_q, mask);
      if (!run) begin
         state_d = IDLE;
         cnt_d   = '0;
         bcnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: if (mask != 8'h00) begin
               state_d = SHOW;
               sel_d   = next_sel(3'd7, mask);
               cnt_d   = '0;
            end
            SHOW: if (cnt_q == div) begin
               state_d = BLANK;
               cnt_d   = '0;
               bcnt_d  = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            BLANK: if (bcnt_q == BW'(BLANK_CYC - 1)) begin
               if (mask == 8'h00) begin
                  state_d = IDLE;
               end else begin
                  state_d = SHOW;
                  sel_d   = nxt;
                  cnt_d   = '0;
                  step_d  = 1'b1;
                  frame_d = nxt <= sel_q;
               end
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
      en_d = state_d == SHOW;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         en_q    <= 1'b0;
         step_q  <= 1'b0;
         frame_q <= 1'b0;
         cnt_q   <= '0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         step_q  <= step_d;
         frame_q <= frame_d;
         cnt_q   <= cnt_d;
         bcnt_q  <= bcnt_d;
      end
   end
   assign sel   = sel_q;
   assign en    = en_q;
   assign step  = step_q;
   assign frame = frame_q;
endmodule

// File: tb/tb_dec_scan_ctrl.sv
// tb_dec_scan_ctrl: scoreboard bench; each digit shown is checked against a queued expectation
module tb_dec_scan_ctrl;
   logic        clk, rst, run, en, step, frame;
   logic [15:0] div;
   logic [7:0]  mask;
   logic [2:0]  sel;
   int          checks = 0, errors = 0;
   typedef struct {
      int sel;
      int step;
      int frame;
      int len;
      int gap;
   } exp_t;
   exp_t q[$];
   exp_t cur;
   logic active = 1'b0, en_prev = 1'b0;
   int   hi = 0, low = 0;
   dec_scan_ctrl #(.DIV_W(16), .BLANK_CYC(2)) dut (
      .clk(clk), .rst(rst), .run(run), .div(div), .mask(mask),
      .sel(sel), .en(en), .step(step), .frame(frame)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic push(input int s, input int st, input int fr, input int len, input int gap);
      exp_t e;
      e.sel = s; e.step = st; e.frame = fr; e.len = len; e.gap = gap;
      q.push_back(e);
   endtask
   // mode 0: all queued digits shown and finished; mode 1: last queued digit currently showing
   task automatic wait_until(input int mode, input int lim);
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         #1;
         if (q.size() == 0 && active == (mode == 1)) return;
      end
      checks++;
      errors++;
      $display("FAIL wait_timeout: mode %0d queue %0d active %0d", mode, q.size(), active);
   endtask
   task automatic chk_quiet(input string nm, input int s);
      chk({nm, "_en"}, int'(en), 0);
      chk({nm, "_sel"}, int'(sel), s);
      chk({nm, "_step"}, int'(step), 0);
      chk({nm, "_frame"}, int'(frame), 0);
   endtask
   // monitor: pops an expectation at each rising en and checks dwell, gap and pulses
   always @(negedge clk) begin
      if (en && !en_prev) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_show: sel %0d with empty queue at %0t", sel, $time);
         end else begin
            cur = q.pop_front();
            active = 1'b1;
            hi = 0;
            chk("show_sel", int'(sel), cur.sel);
            chk("show_step", int'(step), cur.step);
            chk("show_frame", int'(frame), cur.frame);
            if (cur.gap != 0) chk("blank_gap", low, cur.gap);
         end
      end else begin
         chk("pulse_idle", int'(step | frame), 0);
         if (!en && en_prev) begin
            if (active && cur.len != 0) chk("dwell_len", hi, cur.len);
            active = 1'b0;
            low = 0;
         end
      end
      if (en) begin
         hi++;
         if (active) chk("sel_stable", int'(sel), cur.sel);
      end else begin
         low++;
      end
      en_prev = en;
   end
   initial begin
      #200000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "timeout");
   end
   initial begin
      rst = 1'b1; run = 1'b1; mask = 8'hFF; div = 16'd3;
      repeat (3) begin
         @(negedge clk);
         #1;
         chk_quiet("reset", 0);
      end
      push(0, 0, 0, 4, 0);
      for (int i = 1; i < 8; i++) push(i, 1, 0, 4, 2);
      push(0, 1, 1, 4, 2);
      push(1, 1, 0, 4, 2);
      rst = 1'b0;
      wait_until(0, 200);
      run = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      mask = 8'b1010_0100; div = 16'd0;
      push(2, 0, 0, 1, 0);
      push(5, 1, 0, 1, 2);
      push(7, 1, 0, 1, 2);
      push(2, 1, 1, 1, 2);
      push(5, 1, 0, 1, 2);
      run = 1'b1;
      wait_until(1, 100);
      mask = 8'h01;
      push(0, 1, 1, 1, 2);
      wait_until(0, 50);
      run = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      mask = 8'h10; div = 16'd1;
      push(4, 0, 0, 2, 0);
      push(4, 1, 1, 2, 2);
      push(4, 1, 1, 2, 2);
      run = 1'b1;
      wait_until(0, 100);
      run = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      mask = 8'hFF; div = 16'd3;
      push(0, 0, 0, 4, 0);
      push(1, 1, 0, 4, 2);
      push(2, 1, 0, 4, 2);
      push(3, 1, 0, 2, 2);
      run = 1'b1;
      wait_until(1, 100);
      @(negedge clk);
      #1;
      run = 1'b0;
      repeat (2) begin
         @(negedge clk);
         #1;
         chk_quiet("stopped", 3);
      end
      wait_until(0, 20);
      push(0, 0, 0, 4, 0);
      push(1, 1, 0, 4, 2);
      run = 1'b1;
      wait_until(0, 100);
      run = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      mask = 8'h00;
      run = 1'b1;
      repeat (6) begin
         @(negedge clk);
         #1;
         chk_quiet("empty_mask", 1);
      end
      mask = 8'hFF;
      push(0, 0, 0, 4, 0);
      push(1, 1, 0, 4, 2);
      push(2, 1, 0, 0, 2);
      wait_until(1, 100);
      #2;
      rst = 1'b1;
      #1;
      chk_quiet("async_reset", 0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      run = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
